// File: rtl/alu_exec_stage_if.sv
// Instruction handshake plus the operand/result bus between the execute stage and the ALU.
interface alu_exec_stage_if #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6
);
  logic                     instr_valid;
  logic [15:0]              instr;
  logic                     instr_ready;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [ALU_CONT_BITS-1:0] alu_cont;
  logic [WIDTH-1:0]         alu_out;
  logic [WIDTH-1:0]         psr_flags;

  // master: instruction source and ALU; slave: the execute stage
  modport master (
    output instr_valid, instr, alu_out, psr_flags,
    input  instr_ready, alu_a, alu_b, alu_cont
  );
  modport slave (
    input  instr_valid, instr, alu_out, psr_flags,
    output instr_ready, alu_a, alu_b, alu_cont
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Four-clock execute sequencer: decode, drive the external ALU, write back the result
// and the masked flags into the PSR.
module alu_exec_stage #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_exec_stage_if.slave          bus,
  output logic [WIDTH-1:0]         psr,
  output logic                     done,
  output logic                     illegal,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int NREG = 1 << REG_ADDR_BITS;

  localparam logic [ALU_CONT_BITS-1:0] CONT_LSH = ALU_CONT_BITS'(6'b100101);
  localparam logic [ALU_CONT_BITS-1:0] CONT_LUI = ALU_CONT_BITS'(6'b111111);
  localparam logic [WIDTH-1:0]         MASK_CF  = WIDTH'(16'h0021);
  localparam logic [WIDTH-1:0]         MASK_NZL = WIDTH'(16'h00C4);

  typedef enum logic [1:0] {ST_IDLE, ST_DEC, ST_EXE, ST_WB} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                instr_q, instr_d;
  logic [WIDTH-1:0]           alu_a_q, alu_a_d;
  logic [WIDTH-1:0]           alu_b_q, alu_b_d;
  logic [ALU_CONT_BITS-1:0]   alu_cont_q, alu_cont_d;
  logic                       illegal_q, illegal_d;
  logic                       wr_q, wr_d;
  logic [WIDTH-1:0]           mask_q, mask_d;
  logic [WIDTH-1:0]           res_q, res_d;
  logic [WIDTH-1:0]           flags_q, flags_d;
  logic [WIDTH-1:0]           psr_q, psr_d;
  logic [WIDTH-1:0]           rf_q [NREG];
  logic [WIDTH-1:0]           rf_d [NREG];

  logic [3:0]                 f_op, f_rd, f_ext, f_rs;
  logic [7:0]                 f_imm;
  logic                       dec_legal, dec_imm, dec_sext, dec_wr;
  logic [ALU_CONT_BITS-1:0]   dec_cont;
  logic [WIDTH-1:0]           dec_mask, dec_b;

  assign f_op  = instr_q[15:12];
  assign f_rd  = instr_q[11:8];
  assign f_ext = instr_q[7:4];
  assign f_rs  = instr_q[3:0];
  assign f_imm = instr_q[7:0];

  always_comb begin
    dec_legal = 1'b0;
    dec_imm   = 1'b0;
    dec_sext  = 1'b0;
    dec_cont  = '0;
    case (f_op)
      4'h0: begin
        if (f_ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD}) begin
          dec_legal = 1'b1;
          dec_cont  = ALU_CONT_BITS'({2'b00, f_ext});
        end
      end
      4'h1, 4'h2, 4'h3, 4'h6: begin
        dec_legal = 1'b1;
        dec_imm   = 1'b1;
        dec_cont  = ALU_CONT_BITS'({2'b00, f_op});
      end
      4'h5, 4'h9, 4'hB, 4'hD: begin
        dec_legal = 1'b1;
        dec_imm   = 1'b1;
        dec_sext  = 1'b1;
        dec_cont  = ALU_CONT_BITS'({2'b00, f_op});
      end
      4'h8: begin
        if (f_ext == 4'h4) begin
          dec_legal = 1'b1;
          dec_cont  = CONT_LSH;
        end
      end
      4'hF: begin
        dec_legal = 1'b1;
        dec_imm   = 1'b1;
        dec_cont  = CONT_LUI;
      end
      default: ;
    endcase

    // Flag ownership only applies to the plain class-00 arithmetic codes
    dec_wr   = dec_legal;
    dec_mask = '0;
    if (dec_legal && dec_cont[5:4] == 2'b00) begin
      if (dec_cont[3:0] == 4'h5 || dec_cont[3:0] == 4'h9) begin
        dec_mask = MASK_CF;
      end else if (dec_cont[3:0] == 4'hB) begin
        dec_mask = MASK_NZL;
        dec_wr   = 1'b0;
      end
    end

    if (!dec_imm)      dec_b = rf_q[f_rs];
    else if (dec_sext) dec_b = {{(WIDTH-8){f_imm[7]}}, f_imm};
    else               dec_b = {{(WIDTH-8){1'b0}}, f_imm};
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cont_d = alu_cont_q;
    illegal_d  = illegal_q;
    wr_d       = wr_q;
    mask_d     = mask_q;
    res_d      = res_q;
    flags_d    = flags_q;
    psr_d      = psr_q;
    rf_d       = rf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        alu_a_d    = rf_q[f_rd];
        alu_b_d    = dec_b;
        alu_cont_d = dec_legal ? dec_cont : '0;
        illegal_d  = !dec_legal;
        wr_d       = dec_wr;
        mask_d     = dec_mask;
        state_d    = ST_EXE;
      end
      ST_EXE: begin
        res_d   = bus.alu_out;
        flags_d = bus.psr_flags;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (wr_q) rf_d[f_rd] = res_q;
        psr_d   = (psr_q & ~mask_q) | (flags_q & mask_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cont_q <= '0;
      illegal_q  <= 1'b0;
      wr_q       <= 1'b0;
      mask_q     <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      psr_q      <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cont_q <= alu_cont_d;
      illegal_q  <= illegal_d;
      wr_q       <= wr_d;
      mask_q     <= mask_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      psr_q      <= psr_d;
      rf_q       <= rf_d;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_cont    = alu_cont_q;
  assign psr             = psr_q;
  assign done            = (state_q == ST_WB);
  assign illegal         = (state_q == ST_WB) && illegal_q;
  assign dbg_data        = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with a behavioural 16-bit ALU on the bus.
module tb_alu_exec_stage;
  logic        clk;
  logic        reset;
  logic [15:0] psr;
  logic        done;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  int          nvec;
  int          nerr;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .psr      (psr),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; unowned flag bits carry noise so PSR masking is exercised
  logic [16:0] wide;
  always_comb begin
    bus.alu_out   = 16'hDEAD;
    bus.psr_flags = 16'hFFFF;
    wide          = '0;
    if (bus.alu_cont != 6'h00) begin
      case (bus.alu_cont)
        6'h01: wide = {1'b0, bus.alu_a & bus.alu_b};
        6'h02: wide = {1'b0, bus.alu_a | bus.alu_b};
        6'h03: wide = {1'b0, bus.alu_a ^ bus.alu_b};
        6'h05, 6'h06: wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        6'h09, 6'h0B: wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        6'h0D: wide = {1'b0, bus.alu_b};
        6'h25: wide = {1'b0, bus.alu_a << bus.alu_b[3:0]};
        6'h3F: wide = {1'b0, bus.alu_b[7:0], 8'h00};
        default: wide = 17'h0DEAD;
      endcase
      bus.alu_out      = wide[15:0];
      bus.psr_flags    = '0;
      bus.psr_flags[6] = (wide[15:0] == 16'h0000);
      bus.psr_flags[7] = wide[15];
      if (bus.alu_cont == 6'h05) begin
        bus.psr_flags[0] = wide[16];
        bus.psr_flags[5] = (bus.alu_a[15] == bus.alu_b[15]) && (wide[15] != bus.alu_a[15]);
      end else if (bus.alu_cont == 6'h09) begin
        bus.psr_flags[0] = wide[16];
        bus.psr_flags[5] = (bus.alu_a[15] != bus.alu_b[15]) && (wide[15] != bus.alu_a[15]);
      end else if (bus.alu_cont == 6'h0B) begin
        bus.psr_flags[0] = 1'b1;
        bus.psr_flags[5] = 1'b1;
        bus.psr_flags[2] = (bus.alu_a < bus.alu_b);
        bus.psr_flags[6] = (bus.alu_a == bus.alu_b);
        bus.psr_flags[7] = ($signed(bus.alu_a) < $signed(bus.alu_b));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Called at a negedge; returns at the negedge after the write edge
  task automatic issue(input logic [15:0] ins, input logic exp_ill);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", bus.instr_ready, 1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_dec", bus.instr_ready, 0);
    chk("done_dec", done, 0);
    @(negedge clk);
    chk("done_exe", done, 0);
    @(negedge clk);
    chk("done_wb", done, 1);
    chk("illegal_wb", illegal, exp_ill);
    @(negedge clk);
    chk("done_after", done, 0);
    $display("instr %h issued, psr=%h, illegal_exp=%0d", ins, psr, exp_ill);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nvec            = 0;
    nerr            = 0;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    dbg_addr        = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_cont", bus.alu_cont, 0);
    chk("rst_psr", psr, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    reset = 1'b0;
    @(negedge clk);

    // ADDI r1,#05
    issue(16'h5105, 0);
    rd_chk("t1_r1", 4'h1, 16'h0005);
    chk("t1_psr", psr, 16'h0000);

    // r1=0x7FFF, r2=1, ADD r1,r2 -> overflow
    issue(16'hF17F, 0);
    issue(16'h21FF, 0);
    issue(16'hD201, 0);
    rd_chk("t2_r1_pre", 4'h1, 16'h7FFF);
    issue(16'h0152, 0);
    rd_chk("t2_r1", 4'h1, 16'h8000);
    chk("t2_psr", psr, 16'h0020);

    // SUBI r3,#FF: sign-extended -1
    issue(16'h93FF, 0);
    chk("t3_alu_b", bus.alu_b, 16'hFFFF);
    rd_chk("t3_r3", 4'h3, 16'h0001);
    chk("t3_psr", psr, 16'h0001);

    // r4=r5=0x1234, CMP r4,r5
    issue(16'hF412, 0);
    issue(16'h2434, 0);
    issue(16'hF512, 0);
    issue(16'h2534, 0);
    issue(16'h04B5, 0);
    rd_chk("t4_r4", 4'h4, 16'h1234);
    chk("t4_psr", psr, 16'h0041);

    // LUI r6,#AB then undecodable encodings
    issue(16'hF6AB, 0);
    rd_chk("t5_r6", 4'h6, 16'hAB00);
    issue(16'h7000, 1);
    chk("t5_ill_cont", bus.alu_cont, 6'h00);
    rd_chk("t5_r0", 4'h0, 16'h0000);
    chk("t5_psr", psr, 16'h0041);
    issue(16'h0146, 1);
    rd_chk("t5_r1", 4'h1, 16'h8000);

    // LSH r2,r2 (shift by 1); rdest == rsrc
    issue(16'h8242, 0);
    chk("lsh_cont", bus.alu_cont, 6'h25);
    rd_chk("lsh_r2", 4'h2, 16'h0002);
    chk("lsh_psr", psr, 16'h0041);

    // ADDI r7,#01 aborted by reset during EXE
    bus.instr       = 16'h5701;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", bus.instr_ready, 1);
    chk("t6_done", done, 0);
    rd_chk("t6_r7", 4'h7, 16'h0000);
    rd_chk("t6_r6", 4'h6, 16'h0000);
    chk("t6_psr", psr, 16'h0000);
    $display("reset during EXE of instr 5701 checked");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
